// File: rtl/hack_mem_bus.sv
// hack_mem_bus: Hack CPU data-port interconnect. Decodes each access into a
// one-hot region select, rebases the address to a region-local offset,
// realigns slave read data to the read latency, and captures illegal accesses.

// Per-region decoder: hit test and local offset for one address window.
module hack_mem_region #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] BASE  = '0,
  parameter logic [WIDTH-1:0] LIMIT = '0
) (
  input  logic [WIDTH-1:0] addr,
  output logic             hit,
  output logic [WIDTH-1:0] off
);
  // An empty or inverted window can never hit.
  localparam logic             NONEMPTY = (LIMIT > BASE);
  localparam logic [WIDTH-1:0] SPAN     = LIMIT - BASE;

  // base <= addr < limit is the same as the modular offset being below the
  // window span; this also yields the rebased address for free.
  assign off = addr - BASE;
  assign hit = NONEMPTY && (off < SPAN);
endmodule

module hack_mem_bus #(
  parameter int                           WIDTH       = 16,
  parameter int                           NUM_REGIONS = 3,
  parameter logic [NUM_REGIONS*WIDTH-1:0] REGION_BASE = {16'd24576, 16'd16384, 16'd0},
  parameter logic [NUM_REGIONS*WIDTH-1:0] REGION_END  = {16'd24577, 16'd24576, 16'd16384},
  parameter int                           RD_LATENCY  = 1,
  parameter int                           CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [WIDTH-1:0]             cpu_addr,
  input  logic [WIDTH-1:0]             cpu_wdata,
  input  logic                         cpu_write,
  input  logic                         cpu_access,
  output logic [WIDTH-1:0]             cpu_rdata,
  output logic [NUM_REGIONS-1:0]       slv_sel,
  output logic [NUM_REGIONS-1:0]       slv_write,
  output logic [WIDTH-1:0]             slv_addr,
  output logic [WIDTH-1:0]             slv_wdata,
  input  logic [NUM_REGIONS*WIDTH-1:0] slv_rdata,
  output logic                         invalid_addr,
  input  logic                         err_clear,
  output logic                         err_valid,
  output logic [WIDTH-1:0]             err_addr,
  output logic                         err_write,
  output logic [CNT_W-1:0]             err_count
);
  logic [NUM_REGIONS-1:0]            hit;
  logic [NUM_REGIONS-1:0][WIDTH-1:0] off;
  logic [RD_LATENCY-1:0][NUM_REGIONS-1:0] sel_pipe;
  logic [NUM_REGIONS-1:0]            pipe_out;

  genvar g;
  generate
    for (g = 0; g < NUM_REGIONS; g++) begin : g_region
      hack_mem_region #(
        .WIDTH (WIDTH),
        .BASE  (REGION_BASE[g*WIDTH +: WIDTH]),
        .LIMIT (REGION_END[g*WIDTH +: WIDTH])
      ) u_region (
        .addr (cpu_addr),
        .hit  (hit[g]),
        .off  (off[g])
      );
    end
  endgenerate

  // Priority select: lowest-index hit wins so the select stays one-hot.
  always_comb begin
    logic found;
    found    = 1'b0;
    slv_sel  = '0;
    slv_addr = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!found && hit[i]) begin
        slv_sel[i] = 1'b1;
        slv_addr   = off[i];
        found      = 1'b1;
      end
    end
  end

  assign invalid_addr = ~|slv_sel;
  assign slv_write    = slv_sel & {NUM_REGIONS{cpu_write}};
  assign slv_wdata    = cpu_wdata;

  // Select delay line: runs every cycle so read data lines up with its request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_pipe <= '0;
    end else begin
      sel_pipe[0] <= slv_sel;
      for (int i = 1; i < RD_LATENCY; i++) sel_pipe[i] <= sel_pipe[i-1];
    end
  end

  assign pipe_out = sel_pipe[RD_LATENCY-1];

  // Read mux: empty delayed select (invalid read) returns zero.
  always_comb begin
    cpu_rdata = '0;
    for (int i = 0; i < NUM_REGIONS; i++)
      if (pipe_out[i]) cpu_rdata = cpu_rdata | slv_rdata[i*WIDTH +: WIDTH];
  end

  logic             illegal;
  logic             valid_d, write_d;
  logic [WIDTH-1:0] addr_d;
  logic [CNT_W-1:0] cnt_d, cnt_base;

  assign illegal = (cpu_access | cpu_write) & invalid_addr;

  // Error next state: clear is applied first, then any capture on top of it.
  always_comb begin
    valid_d  = err_valid & ~err_clear;
    addr_d   = err_clear ? '0 : err_addr;
    write_d  = err_write & ~err_clear;
    cnt_base = err_clear ? '0 : err_count;
    cnt_d    = cnt_base;
    if (illegal) begin
      if (!valid_d) begin
        valid_d = 1'b1;
        addr_d  = cpu_addr;
        write_d = cpu_write;
      end
      if (cnt_base != {CNT_W{1'b1}}) cnt_d = cnt_base + CNT_W'(1);
    end
  end

  // Error capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_write <= 1'b0;
      err_count <= '0;
    end else begin
      err_valid <= valid_d;
      err_addr  <= addr_d;
      err_write <= write_d;
      err_count <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hack_mem_bus.sv
// Directed bench for hack_mem_bus: default map at latency 1, a latency-3 /
// 2-bit-counter copy, and a two-region overlapping map, all on shared inputs.
module tb_hack_mem_bus;
  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] cpu_addr = 16'd30000;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_write = 1'b0;
  logic        cpu_access = 1'b0;
  logic        err_clear = 1'b0;
  logic [47:0] rdata3 = {16'h3333, 16'h2222, 16'h1111};
  logic [31:0] rdata2 = {16'h2222, 16'h1111};

  // default instance outputs
  logic [15:0] a_rdata, a_saddr, a_swdata, a_eaddr;
  logic [2:0]  a_sel, a_swr;
  logic        a_inv, a_ev, a_ew;
  logic [7:0]  a_cnt;
  // latency-3 instance outputs
  logic [15:0] b_rdata, b_saddr, b_swdata, b_eaddr;
  logic [2:0]  b_sel, b_swr;
  logic        b_inv, b_ev, b_ew;
  logic [1:0]  b_cnt;
  // overlap instance outputs
  logic [15:0] c_rdata, c_saddr, c_swdata, c_eaddr;
  logic [1:0]  c_sel, c_swr;
  logic        c_inv, c_ev, c_ew;
  logic [7:0]  c_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  hack_mem_bus u_dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_write(cpu_write), .cpu_access(cpu_access), .cpu_rdata(a_rdata),
    .slv_sel(a_sel), .slv_write(a_swr), .slv_addr(a_saddr), .slv_wdata(a_swdata),
    .slv_rdata(rdata3), .invalid_addr(a_inv), .err_clear(err_clear),
    .err_valid(a_ev), .err_addr(a_eaddr), .err_write(a_ew), .err_count(a_cnt)
  );

  hack_mem_bus #(.RD_LATENCY(3), .CNT_W(2)) u_lat3 (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_write(cpu_write), .cpu_access(cpu_access), .cpu_rdata(b_rdata),
    .slv_sel(b_sel), .slv_write(b_swr), .slv_addr(b_saddr), .slv_wdata(b_swdata),
    .slv_rdata(rdata3), .invalid_addr(b_inv), .err_clear(err_clear),
    .err_valid(b_ev), .err_addr(b_eaddr), .err_write(b_ew), .err_count(b_cnt)
  );

  hack_mem_bus #(.NUM_REGIONS(2), .REGION_BASE({16'd50, 16'd0}),
                 .REGION_END({16'd200, 16'd100})) u_ovl (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_write(cpu_write), .cpu_access(cpu_access), .cpu_rdata(c_rdata),
    .slv_sel(c_sel), .slv_write(c_swr), .slv_addr(c_saddr), .slv_wdata(c_swdata),
    .slv_rdata(rdata2), .invalid_addr(c_inv), .err_clear(err_clear),
    .err_valid(c_ev), .err_addr(c_eaddr), .err_write(c_ew), .err_count(c_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock, sample 1 ns after the edge, retire due read results
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    while (qa.size() > 0 && qa[0].due <= cyc) begin
      exp_t e;
      e = qa.pop_front();
      chk("rdata_lat1", {16'h0, a_rdata}, {16'h0, e.data});
    end
    while (qb.size() > 0 && qb[0].due <= cyc) begin
      exp_t e;
      e = qb.pop_front();
      chk("rdata_lat3", {16'h0, b_rdata}, {16'h0, e.data});
    end
  endtask

  task automatic push_read(input logic [15:0] exp_data, input bit both);
    qa.push_back('{due: cyc + 1, data: exp_data});
    if (both) qb.push_back('{due: cyc + 3, data: exp_data});
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("rst_rdata", {16'h0, a_rdata}, 32'h0);
    chk("rst_err_valid", {31'h0, a_ev}, 32'h0);
    chk("rst_err_count", {24'h0, a_cnt}, 32'h0);
    step();
    step();
    reset_n = 1'b1;

    // write decode into region 1
    cpu_addr = 16'd16400; cpu_wdata = 16'hBEEF; cpu_write = 1'b1;
    #1;
    chk("wr_sel", {29'h0, a_sel}, 32'b010);
    chk("wr_strobe", {29'h0, a_swr}, 32'b010);
    chk("wr_addr", {16'h0, a_saddr}, 32'd16);
    chk("wr_wdata", {16'h0, a_swdata}, 32'hBEEF);
    chk("wr_invalid", {31'h0, a_inv}, 32'h0);
    step();
    cpu_write = 1'b0;
    chk("wr_no_err", {31'h0, a_ev}, 32'h0);

    // back-to-back reads across three regions
    cpu_access = 1'b1;
    cpu_addr = 16'd5;     push_read(16'h1111, 1'b1); step();
    cpu_addr = 16'd16384; push_read(16'h2222, 1'b1); step();
    cpu_addr = 16'd24576; push_read(16'h3333, 1'b1); step();
    cpu_access = 1'b0; cpu_addr = 16'd30000;
    step(); step(); step();
    chk("stream_drained", qa.size() + qb.size(), 32'd0);
    chk("idle_invalid", {31'h0, a_inv}, 32'h1);
    chk("idle_no_err", {31'h0, a_ev}, 32'h0);
    chk("idle_cnt", {24'h0, a_cnt}, 32'h0);

    // illegal read
    cpu_access = 1'b1; cpu_addr = 16'd30000;
    push_read(16'h0, 1'b1);
    step();
    cpu_access = 1'b0;
    chk("ill_valid", {31'h0, a_ev}, 32'h1);
    chk("ill_addr", {16'h0, a_eaddr}, 32'd30000);
    chk("ill_write", {31'h0, a_ew}, 32'h0);
    chk("ill_cnt", {24'h0, a_cnt}, 32'd1);

    // further illegal writes: sticky capture, counting, saturation at CNT_W=2
    cpu_write = 1'b1; cpu_addr = 16'd30001; step();
    cpu_addr = 16'd40000;
    #1;
    chk("ill_no_strobe", {29'h0, a_swr}, 32'h0);
    step();
    cpu_write = 1'b0;
    chk("sticky_addr", {16'h0, a_eaddr}, 32'd30000);
    chk("sticky_write", {31'h0, a_ew}, 32'h0);
    chk("cnt3", {24'h0, a_cnt}, 32'd3);
    cpu_write = 1'b1; step(); step();
    cpu_write = 1'b0;
    chk("cnt5", {24'h0, a_cnt}, 32'd5);
    chk("sat_cnt", {30'h0, b_cnt}, 32'd3);
    chk("lat3_drained", qb.size(), 32'd0);

    // clear together with an illegal write, then clear alone
    err_clear = 1'b1; cpu_write = 1'b1; cpu_addr = 16'd50000;
    step();
    err_clear = 1'b0; cpu_write = 1'b0; cpu_addr = 16'd30000;
    chk("clr_cap_valid", {31'h0, a_ev}, 32'h1);
    chk("clr_cap_addr", {16'h0, a_eaddr}, 32'd50000);
    chk("clr_cap_write", {31'h0, a_ew}, 32'h1);
    chk("clr_cap_cnt", {24'h0, a_cnt}, 32'd1);
    chk("clr_cap_cnt3", {30'h0, b_cnt}, 32'd1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("clr_valid", {31'h0, a_ev}, 32'h0);
    chk("clr_addr", {16'h0, a_eaddr}, 32'h0);
    chk("clr_write", {31'h0, a_ew}, 32'h0);
    chk("clr_cnt", {24'h0, a_cnt}, 32'h0);

    // decode boundaries and overlap priority (combinational only)
    cpu_addr = 16'd60; #1;
    chk("ovl_sel", {30'h0, c_sel}, 32'b01);
    chk("ovl_addr", {16'h0, c_saddr}, 32'd60);
    cpu_addr = 16'd150; #1;
    chk("ovl_sel_r1", {30'h0, c_sel}, 32'b10);
    chk("ovl_addr_r1", {16'h0, c_saddr}, 32'd100);
    cpu_addr = 16'd16383; #1;
    chk("bnd_16383_sel", {29'h0, a_sel}, 32'b001);
    chk("bnd_16383_addr", {16'h0, a_saddr}, 32'd16383);
    cpu_addr = 16'd24575; #1;
    chk("bnd_24575_sel", {29'h0, a_sel}, 32'b010);
    chk("bnd_24575_addr", {16'h0, a_saddr}, 32'd8191);
    cpu_addr = 16'd24577; #1;
    chk("bnd_24577_sel", {29'h0, a_sel}, 32'b000);
    chk("bnd_24577_addr", {16'h0, a_saddr}, 32'h0);
    chk("bnd_24577_inv", {31'h0, a_inv}, 32'h1);

    // reset in the middle of a read
    cpu_access = 1'b1; cpu_addr = 16'd30000; push_read(16'h0, 1'b0); step();
    cpu_addr = 16'd16384; push_read(16'h2222, 1'b0); step();
    chk("pre_rst_valid", {31'h0, a_ev}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rdata", {16'h0, a_rdata}, 32'h0);
    chk("mid_rst_rdata3", {16'h0, b_rdata}, 32'h0);
    chk("mid_rst_valid", {31'h0, a_ev}, 32'h0);
    chk("mid_rst_addr", {16'h0, a_eaddr}, 32'h0);
    chk("mid_rst_cnt", {24'h0, a_cnt}, 32'h0);
    cpu_access = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("final_drained", qa.size() + qb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
